window_former: RTL and testbench

WINDOW_FORMER -- requirements
Module: window_former

---
 rtl/window_former.sv | 147 ++++++++++++++
 tb/tb_window_former.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_former.sv
`default_nettype none
// window_former: turns a stream of WIN_SIZE-tall column beats into
// WIN_SIZE x WIN_SIZE x CH_NUM sliding windows with row/column stride.
module window_former #(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DIN_WIDTH   = 8,
  parameter int WIN_SIZE    = 3,
  parameter int CH_NUM      = 3,
  parameter int STRIDE      = 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [$clog2(FRAME_H_MAX):0]                           frame_h,
  input  logic [$clog2(FRAME_W_MAX):0]                           frame_w,
  input  logic                                                   frame_start,
  input  logic                                                   din_vld,
  input  logic [WIN_SIZE-1:0][CH_NUM-1:0][DIN_WIDTH-1:0]         din_col,
  output logic                                                   win_vld,
  output logic [WIN_SIZE-1:0][WIN_SIZE-1:0][CH_NUM-1:0][DIN_WIDTH-1:0] win,
  output logic                                                   win_first,
  output logic                                                   win_last,
  output logic                                                   frame_done,
  output logic                                                   err_cfg,
  output logic                                                   err_abort
);

  localparam int HW = $clog2(FRAME_H_MAX) + 1;
  localparam int WW = $clog2(FRAME_W_MAX) + 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [HW-1:0] H_MAX     = HW'(FRAME_H_MAX);
  localparam logic [WW-1:0] W_MAX     = WW'(FRAME_W_MAX);
  localparam logic [HW-1:0] WIN_H     = HW'(WIN_SIZE);
  localparam logic [WW-1:0] WIN_W     = WW'(WIN_SIZE);
  localparam logic [WW-1:0] W_ONE     = WW'(1);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [WW-1:0] COL_FIRST = WW'(WIN_SIZE - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);
  localparam logic [PW-1:0] PH_ONE    = PW'(1);
  localparam logic [HW:0]   ROW_REACH = (HW+1)'(STRIDE + WIN_SIZE);
  localparam logic [WW:0]   COL_REACH = (WW+1)'(STRIDE);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  typedef logic [WIN_SIZE-1:0][CH_NUM-1:0][DIN_WIDTH-1:0] col_t;

  logic [0:0]    state, state_nxt;
  logic [HW-1:0] fh, row;
  logic [WW-1:0] fw, col;
  logic [PW-1:0] col_ph, row_ph;
  col_t          hist [WIN_SIZE-1];

  logic cfg_bad, col_last, row_last, pos_ok, last_pos;
  logic accept, emit, done_beat, abort;

  assign cfg_bad  = (frame_w < WIN_W) || (frame_h < WIN_H) ||
                    (frame_w > W_MAX) || (frame_h > H_MAX);
  assign col_last = (col == fw - W_ONE);
  assign row_last = (row == fh - WIN_H);
  assign pos_ok   = (col >= COL_FIRST) && (col_ph == '0) && (row_ph == '0);
  // Last window: no further stride step fits in either dimension.
  assign last_pos = (({1'b0, row} + ROW_REACH) > {1'b0, fh}) &&
                    (({1'b0, col} + COL_REACH) >= {1'b0, fw});

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (frame_start && !cfg_bad) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (frame_start)                            state_nxt = cfg_bad ? S_IDLE : S_ACTIVE;
        else if (din_vld && col_last && row_last)   state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == S_ACTIVE) && din_vld && !frame_start;
    emit      = accept && pos_ok;
    done_beat = accept && col_last && row_last;
    abort     = (state == S_ACTIVE) && frame_start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fh         <= '0;
      fw         <= '0;
      row        <= '0;
      col        <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      win_vld    <= 1'b0;
      win_first  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
      err_cfg    <= 1'b0;
      err_abort  <= 1'b0;
      win        <= '0;
      for (int k = 0; k < WIN_SIZE-1; k++) hist[k] <= '0;
    end else begin
      win_vld    <= emit;
      win_first  <= emit && (row == '0) && (col == COL_FIRST);
      win_last   <= emit && last_pos;
      frame_done <= done_beat;
      err_cfg    <= frame_start && cfg_bad;
      err_abort  <= abort;
      if (frame_start) begin
        fh     <= frame_h;
        fw     <= frame_w;
        row    <= '0;
        col    <= '0;
        col_ph <= '0;
        row_ph <= '0;
      end else if (accept) begin
        hist[0] <= din_col;
        for (int k = 1; k < WIN_SIZE-1; k++) hist[k] <= hist[k-1];
        if (col_last) begin
          col    <= '0;
          col_ph <= '0;
          row    <= row + H_ONE;
          row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + PH_ONE;
        end else begin
          col <= col + W_ONE;
          if (col >= COL_FIRST) col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + PH_ONE;
        end
        // Window data only loads on emit so it stays stable between windows.
        if (emit) begin
          for (int r = 0; r < WIN_SIZE; r++) begin
            win[r][0] <= din_col[r];
            for (int c = 1; c < WIN_SIZE; c++) win[r][c] <= hist[c-1][r];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_former.sv
`default_nettype none
// Directed bench for window_former: 5x5 frames of 3-channel pixels,
// 3x3 windows, one instance at stride 1 and one at stride 2.
module tb_window_former;
  localparam int W = 3, CH = 3, DW = 8;
  typedef logic [W-1:0][W-1:0][CH-1:0][DW-1:0] win_t;
  typedef logic [W-1:0][CH-1:0][DW-1:0] col_t;
  typedef struct { int cyc; win_t w; logic first; logic last; } rec_t;

  logic clk = 1'b0;
  logic reset, frame_start, din_vld;
  logic [8:0] frame_h, frame_w;
  col_t din_col;
  logic v1, f1, l1, d1, ec1, ea1;
  logic v2, f2, l2, d2, ec2, ea2;
  win_t w1, w2;

  int checks = 0, failures = 0, cyc = 0;
  rec_t q1[$], q2[$];
  int done1_n = 0, done1_cyc = 0, done2_n = 0, ecfg_n = 0, eab_n = 0;
  int beat_cyc[15];

  window_former #(.STRIDE(1)) dut1 (
    .clk(clk), .reset(reset), .frame_h(frame_h), .frame_w(frame_w),
    .frame_start(frame_start), .din_vld(din_vld), .din_col(din_col),
    .win_vld(v1), .win(w1), .win_first(f1), .win_last(l1),
    .frame_done(d1), .err_cfg(ec1), .err_abort(ea1));

  window_former #(.STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .frame_h(frame_h), .frame_w(frame_w),
    .frame_start(frame_start), .din_vld(din_vld), .din_col(din_col),
    .win_vld(v2), .win(w2), .win_first(f2), .win_last(l2),
    .frame_done(d2), .err_cfg(ec2), .err_abort(ea2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v1) q1.push_back(rec_t'{cyc, w1, f1, l1});
    if (v2) q2.push_back(rec_t'{cyc, w2, f2, l2});
    if (d1) begin done1_n <= done1_n + 1; done1_cyc <= cyc; end
    if (d2) done2_n <= done2_n + 1;
    if (ec1) ecfg_n <= ecfg_n + 1;
    if (ea1) eab_n <= eab_n + 1;
  end

  function automatic logic [7:0] pix(int r, int c, int ch);
    logic [7:0] v;
    v = {r[2:0], c[2:0], ch[1:0]};
    return v;
  endfunction

  // Beat for output row r carries frame rows r+2 (index 0) .. r (index 2).
  function automatic col_t mkcol(int r, int c);
    col_t x;
    for (int k = 0; k < W; k++)
      for (int ch = 0; ch < CH; ch++) x[k][ch] = pix(r + W - 1 - k, c, ch);
    return x;
  endfunction

  function automatic win_t exp_win(int r, int c);
    win_t x;
    for (int k = 0; k < W; k++)
      for (int j = 0; j < W; j++)
        for (int ch = 0; ch < CH; ch++) x[k][j][ch] = pix(r + W - 1 - k, c - j, ch);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(int h, int w);
    frame_h = 9'(h); frame_w = 9'(w);
    frame_start = 1'b1; din_vld = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_beats(int first, int n, bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          din_vld = 1'b0;
          for (int k = 0; k < W; k++)
            for (int ch = 0; ch < CH; ch++) din_col[k][ch] = 8'($urandom);
          tick();
        end
      end
      din_vld = 1'b1;
      din_col = mkcol(i / 5, i % 5);
      tick();
      beat_cyc[i] = cyc;
    end
    din_vld = 1'b0;
  endtask

  task automatic test_reset();
    int b1;
    reset = 1'b1; frame_start = 1'b1; frame_h = 9'd5; frame_w = 9'd5;
    din_vld = 1'b1; din_col = mkcol(0, 0);
    tick(); tick();
    checks++;
    if ({v1, f1, l1, d1, ec1, ea1, v2, d2} !== 8'b0) begin
      failures++; $display("FAIL reset_flags: got %b required 00000000", {v1, f1, l1, d1, ec1, ea1, v2, d2});
    end
    checks++;
    if (w1 !== '0) begin failures++; $display("FAIL reset_win: got %h required 0", w1); end
    reset = 1'b0; frame_start = 1'b0; din_vld = 1'b0;
    b1 = q1.size();
    send_beats(0, 5, 0);
    repeat (3) tick();
    checks++;
    if (q1.size() - b1 != 0) begin
      failures++; $display("FAIL reset_overrides_start: got %0d windows required 0", q1.size() - b1);
    end
  endtask

  task automatic test_stride1(bit gaps);
    int b1, bd, r, c;
    b1 = q1.size(); bd = done1_n;
    start_frame(5, 5);
    send_beats(0, 15, gaps);
    repeat (4) tick();
    checks++;
    if (q1.size() - b1 != 9) begin
      failures++; $display("FAIL s1_count gaps=%0d: got %0d required 9", gaps, q1.size() - b1);
    end
    for (int i = 0; i < 9; i++) begin
      if (b1 + i < q1.size()) begin
        r = i / 3; c = i % 3 + 2;
        checks++;
        if (q1[b1+i].w !== exp_win(r, c)) begin
          failures++; $display("FAIL s1_data[%0d]: got %h required %h", i, q1[b1+i].w, exp_win(r, c));
        end
        checks++;
        if (q1[b1+i].first !== (i == 0)) begin
          failures++; $display("FAIL s1_first[%0d]: got %b required %b", i, q1[b1+i].first, i == 0);
        end
        checks++;
        if (q1[b1+i].last !== (i == 8)) begin
          failures++; $display("FAIL s1_last[%0d]: got %b required %b", i, q1[b1+i].last, i == 8);
        end
        checks++;
        if (q1[b1+i].cyc != beat_cyc[r*5+c]) begin
          failures++; $display("FAIL s1_latency[%0d]: got cycle %0d required %0d", i, q1[b1+i].cyc, beat_cyc[r*5+c]);
        end
      end
    end
    checks++;
    if (done1_n - bd != 1) begin
      failures++; $display("FAIL s1_done_count: got %0d required 1", done1_n - bd);
    end
    checks++;
    if (done1_cyc != beat_cyc[14]) begin
      failures++; $display("FAIL s1_done_cycle: got %0d required %0d", done1_cyc, beat_cyc[14]);
    end
  endtask

  task automatic test_stride2();
    int b2, bd, r, c;
    int rs[4] = '{0, 0, 2, 2};
    int cs[4] = '{2, 4, 2, 4};
    b2 = q2.size(); bd = done2_n;
    start_frame(5, 5);
    send_beats(0, 15, 0);
    repeat (4) tick();
    checks++;
    if (q2.size() - b2 != 4) begin
      failures++; $display("FAIL s2_count: got %0d required 4", q2.size() - b2);
    end
    for (int i = 0; i < 4; i++) begin
      if (b2 + i < q2.size()) begin
        r = rs[i]; c = cs[i];
        checks++;
        if (q2[b2+i].w !== exp_win(r, c)) begin
          failures++; $display("FAIL s2_data[%0d]: got %h required %h", i, q2[b2+i].w, exp_win(r, c));
        end
        checks++;
        if ({q2[b2+i].first, q2[b2+i].last} !== {i == 0, i == 3}) begin
          failures++; $display("FAIL s2_first_last[%0d]: got %b%b required %b%b", i,
                               q2[b2+i].first, q2[b2+i].last, i == 0, i == 3);
        end
        checks++;
        if (q2[b2+i].cyc != beat_cyc[r*5+c]) begin
          failures++; $display("FAIL s2_latency[%0d]: got %0d required %0d", i, q2[b2+i].cyc, beat_cyc[r*5+c]);
        end
      end
    end
    checks++;
    if (done2_n - bd != 1) begin
      failures++; $display("FAIL s2_done_count: got %0d required 1", done2_n - bd);
    end
  endtask

  task automatic test_abort();
    int b1, ba;
    b1 = q1.size(); ba = eab_n;
    start_frame(5, 5);
    send_beats(0, 7, 0);
    checks++;
    if (q1.size() - b1 != 3) begin
      failures++; $display("FAIL abort_partial_count: got %0d required 3", q1.size() - b1);
    end
    test_stride1(0);
    checks++;
    if (eab_n - ba != 1) begin
      failures++; $display("FAIL abort_pulse: got %0d required 1", eab_n - ba);
    end
  endtask

  task automatic test_cfg();
    int b1, b2, bc, bd;
    bc = ecfg_n; b1 = q1.size(); b2 = q2.size(); bd = done1_n;
    start_frame(5, 2);
    tick();
    checks++;
    if (ecfg_n - bc != 1) begin
      failures++; $display("FAIL cfg_narrow: got %0d err_cfg pulses required 1", ecfg_n - bc);
    end
    send_beats(0, 15, 0);
    repeat (3) tick();
    checks++;
    if ((q1.size() - b1) + (q2.size() - b2) + (done1_n - bd) != 0) begin
      failures++; $display("FAIL cfg_idle_beats: got %0d outputs required 0",
                           (q1.size() - b1) + (q2.size() - b2) + (done1_n - bd));
    end
    start_frame(250, 5);
    tick();
    checks++;
    if (ecfg_n - bc != 2) begin
      failures++; $display("FAIL cfg_too_tall: got %0d err_cfg pulses required 2", ecfg_n - bc);
    end
  endtask

  task automatic test_reset_mid();
    int b1, bd;
    start_frame(5, 5);
    send_beats(0, 8, 0);
    checks++;
    if (v1 !== 1'b1) begin failures++; $display("FAIL mid_pre_window: got %b required 1", v1); end
    reset = 1'b1; din_vld = 1'b1; din_col = mkcol(1, 3);
    tick();
    checks++;
    if ({v1, f1, l1, d1, ec1, ea1} !== 6'b0 || w1 !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: got %b win %h required 000000 win 0",
                           {v1, f1, l1, d1, ec1, ea1}, w1);
    end
    reset = 1'b0; din_vld = 1'b0;
    b1 = q1.size(); bd = done1_n;
    send_beats(8, 7, 0);
    repeat (3) tick();
    checks++;
    if ((q1.size() - b1) + (done1_n - bd) != 0) begin
      failures++; $display("FAIL mid_reset_ignored: got %0d outputs required 0",
                           (q1.size() - b1) + (done1_n - bd));
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; din_vld = 1'b0;
    frame_h = 9'd5; frame_w = 9'd5; din_col = '0;
    test_reset();
    test_stride1(0);
    checks++;
    if (eab_n != 0) begin failures++; $display("FAIL no_spurious_abort: got %0d required 0", eab_n); end
    test_stride2();
    test_stride1(1);
    test_abort();
    test_cfg();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
